lb_updn_timer: RTL and testbench

Programmable interval timer built on the same 2-bit loadable up/down carry-chain counter semantics as the library's counter slices. It consumes the chain's terminal carry and drives the count enable, which the raw slices leave to the user. A small control FSM adds start/stop, one-shot or auto-reload, and a registered terminal-count pulse. It sits beside the counter primitives as a ready-made timer for fabric logic.

---
 rtl/lb_updn_timer_pkg.sv | 18 +
 rtl/lb_updn_timer_if.sv | 30 +++
 rtl/lb_updn_timer_slice.sv | 42 ++++
 rtl/lb_updn_timer.sv | 96 +++++++++
 tb/tb_lb_updn_timer.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/lb_updn_timer_pkg.sv
// Shared types and constants for the lb_updn_timer block.
//   state_e     : control FSM states (IDLE / RUN / DONE)
//   DIR_UP/DN   : values of CON selecting count direction
//   MODE_*      : values of MODE selecting one-shot or auto-reload
package lb_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic DIR_UP       = 1'b1;
    localparam logic DIR_DN       = 1'b0;
    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/lb_updn_timer_if.sv
// Control/status bundle of the programmable interval timer.
//   slave  : timer side (controls in, count/status out)
//   master : user side (drives controls, observes count/status)
interface lb_updn_timer_if #(
    parameter int WIDTH = 8
);
    logic             SP;     // clock enable for LOAD / count / reload
    logic             CI;     // count enable (carry into bit 0)
    logic             CON;    // 1 = up, 0 = down
    logic             MODE;   // 0 = one-shot, 1 = auto-reload
    logic             LOAD;   // load D into Q and reload register
    logic [WIDTH-1:0] D;      // load value
    logic             START;  // begin / resume counting
    logic             STOP;   // halt counting
    logic [WIDTH-1:0] Q;      // current count
    logic             CO;     // combinational terminal carry
    logic             TC;     // registered terminal-count pulse
    logic             BUSY;   // in RUN
    logic             DONE;   // in DONE

    modport slave (
        input  SP, CI, CON, MODE, LOAD, D, START, STOP,
        output Q, CO, TC, BUSY, DONE
    );

    modport master (
        output SP, CI, CON, MODE, LOAD, D, START, STOP,
        input  Q, CO, TC, BUSY, DONE
    );
endinterface

// File: rtl/lb_updn_timer_slice.sv
// lb2_slice_sync: 2-bit up/down counter cell of a ripple carry chain.
//   clk_i, rstn_i : clock, synchronous active-low clear
//   ld_i, d_i     : load strobe and value (beats counting)
//   en_i          : gate for counting; the cell steps when en_i & ci_i
//   ci_i          : carry/borrow in from the lower cell
//   con_i         : direction, 1 = up
//   q_o           : cell value
//   co_o          : carry/borrow out, ci_i & (all-ones up / all-zero down)
module lb2_slice_sync
    import lb_timer_pkg::*;
(
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       ld_i,
    input  logic [1:0] d_i,
    input  logic       en_i,
    input  logic       ci_i,
    input  logic       con_i,
    output logic [1:0] q_o,
    output logic       co_o
);
    logic [1:0] q_q, q_d;

    always_comb begin
        co_o = ci_i & ((con_i == DIR_UP) ? (q_q == 2'b11) : (q_q == 2'b00));
    end

    always_comb begin
        q_d = q_q;
        if (ld_i)
            q_d = d_i;
        else if (en_i && ci_i)
            q_d = (con_i == DIR_UP) ? q_q + 2'd1 : q_q - 2'd1;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) q_q <= 2'b00;
        else         q_q <= q_d;
    end

    assign q_o = q_q;
endmodule

// File: rtl/lb_updn_timer.sv
// lb_updn_timer: programmable interval timer on a 2-bit-slice up/down chain.
//   CK    : clock, rising edge
//   RSTN  : synchronous active-low reset
//   bus   : control/status bundle (SP, CI, CON, MODE, LOAD, D, START, STOP
//           in; Q, CO, TC, BUSY, DONE out)
// Terminal step (CO while counting) reloads Q from R and pulses TC; one-shot
// mode then parks in DONE, auto-reload keeps running.
module lb_updn_timer
    import lb_timer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              CK,
    input  logic              RSTN,
    lb_updn_timer_if.slave    bus
);
    localparam int NSL = WIDTH / 2;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             tc_q, tc_d;

    logic [NSL:0]     carry;
    logic [WIDTH-1:0] q;
    logic             ld_ext, run_step, term, sl_ld, sl_en;
    logic [WIDTH-1:0] sl_d;

    // LOAD beats everything except reset; a count step needs RUN, no STOP,
    // and the clock enable. CI is folded in through the carry chain.
    assign ld_ext   = bus.LOAD & bus.SP;
    assign run_step = (state_q == ST_RUN) & ~bus.STOP & bus.SP & ~ld_ext;
    assign term     = run_step & carry[NSL];
    // Terminal step reuses the slice load path to reload from R instead of
    // wrapping.
    assign sl_ld    = ld_ext | term;
    assign sl_d     = ld_ext ? bus.D : r_q;
    assign sl_en    = run_step;

    assign carry[0] = bus.CI;

    for (genvar g = 0; g < NSL; g++) begin : g_sl
        lb2_slice_sync u_sl (
            .clk_i  (CK),
            .rstn_i (RSTN),
            .ld_i   (sl_ld),
            .d_i    (sl_d[2*g +: 2]),
            .en_i   (sl_en),
            .ci_i   (carry[g]),
            .con_i  (bus.CON),
            .q_o    (q[2*g +: 2]),
            .co_o   (carry[g+1])
        );
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        tc_d    = 1'b0;
        if (ld_ext) begin
            r_d = bus.D;
            if (state_q == ST_DONE) state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (bus.START && !bus.STOP) state_d = ST_RUN;
                ST_RUN: begin
                    if (bus.STOP) begin
                        state_d = ST_IDLE;
                    end else if (term) begin
                        tc_d = 1'b1;
                        if (bus.MODE == MODE_ONESHOT) state_d = ST_DONE;
                    end
                end
                ST_DONE: if (bus.START && !bus.STOP) state_d = ST_RUN;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CK) begin
        if (!RSTN) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            tc_q    <= tc_d;
        end
    end

    assign bus.Q    = q;
    assign bus.CO   = carry[NSL];
    assign bus.TC   = tc_q;
    assign bus.BUSY = (state_q == ST_RUN);
    assign bus.DONE = (state_q == ST_DONE);
endmodule

// File: tb/tb_lb_updn_timer.sv
// Directed bench for lb_updn_timer (WIDTH = 8).
module tb_lb_updn_timer;
    localparam int W = 8;

    logic CK = 1'b0;
    logic RSTN;
    int   n_chk  = 0;
    int   n_fail = 0;

    lb_updn_timer_if #(.WIDTH(W)) bus ();

    lb_updn_timer #(.WIDTH(W)) dut (
        .CK   (CK),
        .RSTN (RSTN),
        .bus  (bus.slave)
    );

    always #5 CK = ~CK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one rising edge, settle, then sample
    task automatic step();
        @(posedge CK);
        #1;
    endtask

    logic [W-1:0] e_q;
    logic         e_tc;

    initial begin
        RSTN = 1'b0; bus.SP = 1'b1; bus.CI = 1'b1; bus.CON = 1'b0; bus.MODE = 1'b0;
        bus.LOAD = 1'b1; bus.D = 8'h55; bus.START = 1'b1; bus.STOP = 1'b0;
        #1;
        step(); step();
        chk("rst_q", bus.Q, 0);
        chk("rst_busy", bus.BUSY, 0);
        chk("rst_done", bus.DONE, 0);
        chk("rst_tc", bus.TC, 0);

        RSTN = 1'b1; bus.LOAD = 1'b0; bus.START = 1'b0;
        #1;
        chk("co_dn_zero", bus.CO, 1);       // Q=0, down, CI=1
        bus.CON = 1'b1; #1;
        chk("co_up_zero", bus.CO, 0);

        // one-shot down from 3
        bus.CON = 1'b0; bus.LOAD = 1'b1; bus.D = 8'd3;
        step();
        chk("ld3_q", bus.Q, 3);
        bus.LOAD = 1'b0; bus.START = 1'b1;
        step();
        bus.START = 1'b0;
        chk("start_busy", bus.BUSY, 1);
        chk("start_q", bus.Q, 3);
        step(); chk("os_q2", bus.Q, 2);
        step(); chk("os_q1", bus.Q, 1);
        step(); chk("os_q0", bus.Q, 0); chk("os_tc_pre", bus.TC, 0); chk("os_co", bus.CO, 1);
        step();
        chk("os_reload_q", bus.Q, 3); chk("os_tc", bus.TC, 1);
        chk("os_done", bus.DONE, 1); chk("os_busy", bus.BUSY, 0);
        step();
        chk("os_tc_once", bus.TC, 0); chk("os_hold_q", bus.Q, 3); chk("os_done2", bus.DONE, 1);
        bus.STOP = 1'b1;
        step();
        bus.STOP = 1'b0;
        chk("done_stop_ign", bus.DONE, 1);

        // auto-reload up from FC
        bus.LOAD = 1'b1; bus.D = 8'hFC; bus.CON = 1'b1; bus.MODE = 1'b1;
        step();
        bus.LOAD = 1'b0;
        chk("ar_ld_done", bus.DONE, 0); chk("ar_ld_q", bus.Q, 8'hFC);
        bus.START = 1'b1;
        step();
        bus.START = 1'b0;
        chk("ar_busy", bus.BUSY, 1);
        e_q = 8'hFC;
        for (int i = 0; i < 8; i++) begin
            e_tc = (e_q == 8'hFF);
            e_q  = e_tc ? 8'hFC : e_q + 8'd1;
            step();
            chk($sformatf("ar_q%0d", i), bus.Q, e_q);
            chk($sformatf("ar_tc%0d", i), bus.TC, e_tc);
        end
        chk("ar_still_run", bus.BUSY, 1);

        // enable gating, Q = FC in RUN
        bus.CI = 1'b0;
        step(); chk("gate_ci0", bus.Q, 8'hFC);
        bus.CI = 1'b1; bus.SP = 1'b0;
        step(); chk("gate_sp0", bus.Q, 8'hFC);
        bus.SP = 1'b1;
        step(); chk("gate_both", bus.Q, 8'hFD);
        chk("co_not_ff", bus.CO, 0);
        step(); step(); chk("gate_ff", bus.Q, 8'hFF);
        chk("co_ff", bus.CO, 1);
        bus.CI = 1'b0; #1; chk("co_ci0", bus.CO, 0);
        bus.CI = 1'b1; bus.CON = 1'b0; #1; chk("co_ff_dn", bus.CO, 0);
        bus.CON = 1'b1; #1;

        // LOAD with STOP in RUN: load wins, stays RUN, no count
        bus.LOAD = 1'b1; bus.STOP = 1'b1; bus.D = 8'h10;
        step();
        chk("ldstop_q", bus.Q, 8'h10); chk("ldstop_busy", bus.BUSY, 1); chk("ldstop_tc", bus.TC, 0);
        // LOAD with SP = 0 is ignored (and nothing counts)
        bus.STOP = 1'b0; bus.SP = 1'b0; bus.D = 8'h20;
        step();
        chk("ld_sp0_q", bus.Q, 8'h10);
        bus.LOAD = 1'b0; bus.SP = 1'b1; bus.STOP = 1'b1;
        step();
        chk("stop_idle", bus.BUSY, 0); chk("stop_q", bus.Q, 8'h10);
        bus.START = 1'b1;
        step();
        chk("startstop_idle", bus.BUSY, 0); chk("startstop_q", bus.Q, 8'h10);
        bus.START = 1'b0; bus.STOP = 1'b0;

        // reset coincident with a terminal step
        bus.LOAD = 1'b1; bus.D = 8'hFE;
        step();
        bus.LOAD = 1'b0; bus.START = 1'b1;
        step();
        bus.START = 1'b0;
        step(); chk("mr_ff", bus.Q, 8'hFF);
        RSTN = 1'b0;
        step();
        chk("mr_tc", bus.TC, 0); chk("mr_q", bus.Q, 0); chk("mr_busy", bus.BUSY, 0);
        RSTN = 1'b1;
        step();
        chk("mr_tc2", bus.TC, 0); chk("mr_idle_q", bus.Q, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
